// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    OUTPUT   = 2'd2
  } state_t;

  // Extend the low w bits of a to 64 bits, sign- or zero-filling above bit w-1.
  function automatic logic [63:0] ext(input logic [31:0] a, input logic signed_mode,
                                      input int unsigned w);
    logic [63:0] ax;
    logic [63:0] mask;
    logic        neg;
    ax   = {32'd0, a};
    mask = (64'd1 << w) - 64'd1;
    neg  = signed_mode & (|(ax & (64'd1 << (w - 1))));
    ext  = neg ? (ax | ~mask) : (ax & mask);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, shifted multiplicand, multiplier and iteration counter.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_signed_mode,
  output logic [2*WIDTH-1:0]   o_acc_next,
  output logic                 o_last
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_sgn;
  logic [CNT_W-1:0] r_cnt;

  logic [PW-1:0]    w_ext;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_next;
  logic             w_last;

  assign w_ext    = PW'(ext(32'(i_a), i_signed_mode, WIDTH));
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  // The top multiplier bit carries weight -2^(W-1) in two's complement, so it subtracts.
  assign w_acc_next = (w_last & r_sgn) ? (r_acc - w_addend) : (r_acc + w_addend);

  assign o_acc_next = w_acc_next;
  assign o_last     = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sgn    <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= w_ext;
      r_mplier <= i_b;
      r_sgn    <= i_signed_mode;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_seq_param.sv
// Sequential radix-2 multiplier top: handshake FSM around the shift-add datapath.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  state_t               r_state;
  state_t               w_state_d;
  logic                 w_load;
  logic                 w_step;
  logic                 w_c_load;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   r_c;

  mult_shift_add_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_a           (a),
    .i_b           (b),
    .i_signed_mode (signed_mode),
    .o_acc_next    (w_acc_next),
    .o_last        (w_last)
  );

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_c_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load    = 1'b1;
          w_state_d = MULTIPLY;
        end
      end
      MULTIPLY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_c_load  = 1'b1;
          w_state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (in_valid) begin
            w_load    = 1'b1;
            w_state_d = MULTIPLY;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_c     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_c_load) begin
        r_c <= w_acc_next;
      end
    end
  end

  // Combinational from out_ready so a new operand pair can enter on the output handshake.
  assign in_ready  = (r_state == IDLE) | ((r_state == OUTPUT) & out_ready);
  assign out_valid = (r_state == OUTPUT);
  assign busy      = (r_state != IDLE);
  assign c         = r_c;

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param at WIDTH=8 and WIDTH=4.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst;

  logic        v8, r8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;

  logic        v4, r4, s4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  c4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] exp;
    string       nm;
  } vec8_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         s;
    logic [7:0] exp;
    string      nm;
  } vec4_t;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (v8),
    .in_ready    (r8),
    .a           (a8),
    .b           (b8),
    .signed_mode (s8),
    .out_valid   (ov8),
    .out_ready   (or8),
    .c           (c8),
    .busy        (busy8)
  );

  mult_seq_param #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (v4),
    .in_ready    (r4),
    .a           (a4),
    .b           (b4),
    .signed_mode (s4),
    .out_valid   (ov4),
    .out_ready   (or4),
    .c           (c4),
    .busy        (busy4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Integer reference: interpret the w-bit operands, multiply, keep the low 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit s, input int w);
    longint av, bv, p, m;
    m  = (longint'(1) << w) - 1;
    av = longint'({32'd0, a}) & m;
    bv = longint'({32'd0, b}) & m;
    if (s && (((av >> (w - 1)) & 1) == 1)) av = av - (longint'(1) << w);
    if (s && (((bv >> (w - 1)) & 1) == 1)) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (!ov4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s,
                      input logic [15:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(r8), 64'd1);
    v8 = 1'b1; a8 = a; b8 = b; s8 = s; or8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
    wait8(cyc);
    chk({nm, " latency"}, 64'(cyc), 64'd8);
    chk({nm, " c"}, 64'(c8), 64'(exp));
    @(posedge clk); #1;
    chk({nm, " ov/busy/in_ready after"}, 64'({ov8, busy8, r8}), 64'b001);
    chk({nm, " c held"}, 64'(c8), 64'(exp));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit s,
                      input logic [7:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    v4 = 1'b1; a4 = a; b4 = b; s4 = s; or4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; a4 = ~a; b4 = ~b; s4 = ~s;
    wait4(cyc);
    chk({nm, " latency"}, 64'(cyc), 64'd4);
    chk({nm, " c"}, 64'(c4), 64'(exp));
    @(posedge clk); #1;
    chk({nm, " ov/busy after"}, 64'({ov4, busy4}), 64'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t t8[6];
    vec4_t t4[3];
    int    cyc;
    int    cyc2;
    logic [7:0] ra, rb;
    logic [3:0] qa, qb;
    bit         rs;

    t8[0] = '{8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255"};
    t8[1] = '{8'h80,  8'h80,  1'b1, 16'h4000, "s-128x-128"};
    t8[2] = '{8'h80,  8'h7F,  1'b1, 16'hC080, "s-128x127"};
    t8[3] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF, "s-1x1"};
    t8[4] = '{8'h00,  8'hFB,  1'b1, 16'h0000, "s0x-5"};
    t8[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, "s-1x-1"};
    t4[0] = '{4'h8, 4'h8, 1'b1, 8'h40, "w4 s-8x-8"};
    t4[1] = '{4'h7, 4'h8, 1'b1, 8'hC8, "w4 s7x-8"};
    t4[2] = '{4'hF, 4'hF, 1'b0, 8'hE1, "w4 u15x15"};

    rst = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 0;
    v4 = 0; a4 = 0; b4 = 0; s4 = 0; or4 = 0;
    #12;
    chk("reset w8 ov/busy/in_ready", 64'({ov8, busy8, r8}), 64'b001);
    chk("reset w8 c", 64'(c8), 64'd0);
    chk("reset w4 ov/busy/in_ready", 64'({ov4, busy4, r4}), 64'b001);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run8(t8[i].a, t8[i].b, t8[i].s, t8[i].exp, t8[i].nm);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run8(ra, rb, rs, 16'(ref_mul(32'(ra), 32'(rb), rs, 8)), "w8 random");
    end

    // Backpressure: hold out_ready low with a pending request.
    @(negedge clk);
    v8 = 1'b1; a8 = 8'd3; b8 = 8'd5; s8 = 1'b0; or8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'd11; b8 = 8'd13;
    wait8(cyc);
    chk("bp latency", 64'(cyc), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp stall ov/in_ready", 64'({ov8, r8}), 64'b10);
      chk("bp stall c", 64'(c8), 64'h000F);
    end
    @(negedge clk);
    v8 = 1'b0; or8 = 1'b1;
    #1;
    chk("bp in_ready with out_ready", 64'(r8), 64'd1);
    @(posedge clk); #1;
    chk("bp idle after", 64'({ov8, busy8}), 64'b00);
    chk("bp c held", 64'(c8), 64'h000F);

    // Back-to-back: second request accepted on the first output handshake.
    @(negedge clk);
    v8 = 1'b1; a8 = 8'd7; b8 = 8'd6; s8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd2; b8 = 8'd9;
    wait8(cyc);
    chk("b2b first latency", 64'(cyc), 64'd8);
    chk("b2b first c", 64'(c8), 64'h002A);
    @(posedge clk); #1;
    v8 = 1'b0;
    chk("b2b second accepted", 64'({ov8, busy8}), 64'b01);
    wait8(cyc2);
    chk("b2b spacing", 64'(cyc2 + 1), 64'd9);
    chk("b2b second c", 64'(c8), 64'h0012);
    @(posedge clk); #1;
    chk("b2b idle", 64'({ov8, busy8}), 64'b00);

    // Asynchronous reset in the middle of an iteration sequence.
    @(negedge clk);
    v8 = 1'b1; a8 = 8'd5; b8 = 8'd7;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-reset busy", 64'(busy8), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid-reset ov/busy", 64'({ov8, busy8}), 64'b00);
    chk("mid-reset c", 64'(c8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run8(8'd4, 8'd4, 1'b0, 16'h0010, "post-reset 4x4");

    for (int i = 0; i < 3; i++) run4(t4[i].a, t4[i].b, t4[i].s, t4[i].exp, t4[i].nm);

    for (int i = 0; i < 12; i++) begin
      qa = 4'($urandom_range(0, 15));
      qb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      run4(qa, qb, rs, 8'(ref_mul(32'(qa), 32'(qb), rs, 4)), "w4 random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
